// File: rtl/wb_pkg.sv
// Shared types and default widths for the queued Wishbone master.
//   state_t         : bus FSM state (IDLE, BUS)
//   DEF_*           : default parameter values used by wb_master_queued
package wb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DEPTH      = 4;
    localparam int unsigned DEF_TIMEOUT    = 255;

endpackage

// File: rtl/wb_req_fifo.sv
// Request queue for wb_master_queued: synchronous FIFO, DEPTH entries of WIDTH bits.
//   i_CLK, i_RSTN : clock, asynchronous active-low reset (empties the queue)
//   i_push, i_din : write request; ignored when full (even if a pop happens too)
//   i_pop         : read request; ignored when empty
//   o_dout        : head entry (valid while !o_empty)
//   o_full, o_empty : flags derived from registered pointers only
module wb_req_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_CLK,
    input  logic             i_RSTN,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    // One extra wrap bit distinguishes full from empty when indices match.
    logic [AW:0]      wptr_q;
    logic [AW:0]      rptr_q;
    logic             push_ok;
    logic             pop_ok;

    assign o_empty = (wptr_q == rptr_q);
    assign o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;
    assign o_dout  = mem[rptr_q[AW-1:0]];

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop_ok)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (push_ok) mem[wptr_q[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/wb_master_queued.sv
// Queued Wishbone classic master. User requests are queued in order and
// issued one at a time as single classic cycles, with a termination timeout.
//   i_CLK, i_RSTN                 : clock, asynchronous active-low reset
//   o_CYC, o_STB, o_WE            : Wishbone cycle, strobe, write enable
//   o_ADDR, o_DATA, o_SEL         : bus address, write data, byte selects
//   i_DATA, i_ACK, i_ERR          : slave read data, normal / error termination
//   i_req, i_addr, i_wdata, i_we, i_sel : user request (accepted when i_req && o_rdy)
//   o_rdy                         : queue not full
//   o_rsp_vld, o_rdata, o_rsp_err : one-cycle response pulse, read data, error
//   o_busy                        : queue non-empty or bus cycle in progress
module wb_master_queued
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
    input  logic                    i_CLK,
    input  logic                    i_RSTN,
    output logic                    o_CYC,
    output logic                    o_STB,
    output logic                    o_WE,
    output logic [ADDR_WIDTH-1:0]   o_ADDR,
    output logic [DATA_WIDTH-1:0]   o_DATA,
    output logic [DATA_WIDTH/8-1:0] o_SEL,
    input  logic [DATA_WIDTH-1:0]   i_DATA,
    input  logic                    i_ACK,
    input  logic                    i_ERR,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic                    i_we,
    input  logic [DATA_WIDTH/8-1:0] i_sel,
    output logic                    o_rdy,
    output logic                    o_rsp_vld,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_rsp_err,
    output logic                    o_busy
);

    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned ENTRY_W   = 1 + SEL_WIDTH + ADDR_WIDTH + DATA_WIDTH;
    // Counter only needs to reach TIMEOUT-1.
    localparam int unsigned CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_t                 state_q;
    state_t                 state_d;

    logic [ENTRY_W-1:0]     fifo_din;
    logic [ENTRY_W-1:0]     fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop_en;

    logic                   cyc_q;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [SEL_WIDTH-1:0]   sel_q;
    logic [CNT_W-1:0]       cnt_q;

    logic                   rsp_vld_q;
    logic                   rsp_err_q;
    logic [DATA_WIDTH-1:0]  rdata_q;

    logic                   timed_out;
    logic                   term;
    logic                   term_err;
    logic                   rd_ok;

    assign fifo_din = {i_we, i_sel, i_addr, i_wdata};

    wb_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_CLK   (i_CLK),
        .i_RSTN  (i_RSTN),
        .i_push  (i_req),
        .i_din   (fifo_din),
        .i_pop   (pop_en),
        .o_dout  (fifo_dout),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        pop_en   = 1'b0;
        term     = 1'b0;
        term_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop_en  = 1'b1;
                    state_d = BUS;
                end
            end
            BUS: begin
                if (i_ACK || i_ERR || timed_out) begin
                    term = 1'b1;
                    // Error wins over ACK; a timeout with no ACK is an error.
                    term_err = i_ERR || !i_ACK;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rd_ok = term && !term_err && !we_q;

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rsp_vld_q <= term;
            if (term) begin
                rsp_err_q <= term_err;
                rdata_q   <= rd_ok ? i_DATA : '0;
            end
            if (pop_en) begin
                cyc_q  <= 1'b1;
                we_q   <= fifo_dout[ENTRY_W-1];
                sel_q  <= fifo_dout[DATA_WIDTH+ADDR_WIDTH +: SEL_WIDTH];
                addr_q <= fifo_dout[DATA_WIDTH +: ADDR_WIDTH];
                data_q <= fifo_dout[DATA_WIDTH-1:0];
                cnt_q  <= '0;
            end else if (term) begin
                cyc_q  <= 1'b0;
                we_q   <= 1'b0;
                sel_q  <= '0;
                addr_q <= '0;
                data_q <= '0;
            end else if (state_q == BUS) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign o_CYC     = cyc_q;
    assign o_STB     = cyc_q;
    assign o_WE      = we_q;
    assign o_ADDR    = addr_q;
    assign o_DATA    = data_q;
    assign o_SEL     = sel_q;
    assign o_rdy     = !fifo_full;
    assign o_rsp_vld = rsp_vld_q;
    assign o_rsp_err = rsp_err_q;
    assign o_rdata   = rdata_q;
    assign o_busy    = !fifo_empty || (state_q == BUS);

endmodule
